wd_supervisor: RTL and testbench
================================

WD_SUPERVISOR -- requirements
Module: wd_supervisor

Interface
REQ-001 SHALL have parameter N_SRC, default 4: number of heartbeat requesters.
REQ-002 SHALL have parameter RAMP_STEP, default 16: amplitude change per ramp step.
REQ-003 SHALL have parameter RAMP_DIV, default 4: cycles per ramp step (minimum 1).
REQ-004 SHALL have port clk  in  1: single clock; one clock domain; all logic on posedge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-006 SHALL have port arm  in  1: one-cycle pulse; start the RF output.
REQ-007 SHALL have port disarm  in  1: one-cycle pulse; orderly shutdown of the RF output.
REQ-008 SHALL have port clear_fault  in  1: one-cycle pulse; release a latched fault.
REQ-009 SHALL have port hb_req  in  N_SRC: level heartbeat toggles, one bit per requester.
REQ-010 SHALL have port hb_mask  in  N_SRC: 1 = requester allowed to feed the watchdog.
REQ-011 SHALL have port wd_warning, wd_triggered  in  1 each: status from the watchdog timer.
REQ-012 SHALL have port wd_enable, wd_heartbeat, wd_force_reset  out  1 each: controls to the watchdog timer.
REQ-013 SHALL have port rf_enable  out  1: gates the modulator output.
REQ-014 SHALL have port amp_scale  out  8: amplitude multiplier to the datapath.
REQ-015 SHALL have port fault_latched  out  1, fault_count  out  8, state  out  3: status.

Function
REQ-016 SHALL implement states DISABLED, RAMP_UP, RUNNING, WARN, RAMP_DOWN, FAULT; state output = encoding.
- DISABLED: arm -> RAMP_UP.
- RAMP_UP: amp reaches 255 -> RUNNING.
- RUNNING: wd_warning -> WARN.
- WARN: !wd_warning -> RUNNING.
- RAMP_UP/RUNNING/WARN: wd_triggered -> RAMP_DOWN with cause=fault; disarm -> RAMP_DOWN with cause=clean.
- RAMP_DOWN: amp reaches 0 -> FAULT if cause=fault, else DISABLED.
- FAULT: clear_fault -> DISABLED.
REQ-017 SHALL pulse wd_force_reset high for exactly the first cycle of RAMP_UP.
REQ-018 SHALL drive wd_enable=1 in RAMP_UP, RUNNING and WARN only. rf_enable=1 in RAMP_UP, RUNNING, WARN and RAMP_DOWN.
REQ-019 SHALL change amp_scale by RAMP_STEP every RAMP_DIV cycles while in a ramp state: saturating at 255 going up, at 0 going down. Width 8-bit, no wrap.
REQ-020 SHALL begin RAMP_DOWN from the current amp_scale, including an interrupted RAMP_UP.
REQ-021 SHALL give wd_triggered priority over disarm in the same cycle (cause=fault). arm in any state but DISABLED SHALL be ignored. clear_fault outside FAULT SHALL be ignored.
REQ-022 SHALL increment fault_count, saturating at 255, on each entry to RAMP_DOWN with cause=fault.
REQ-023 SHALL hold fault_latched=1 in FAULT. It SHALL clear on the cycle the FSM leaves FAULT.
REQ-024 SHALL detect a heartbeat edge as any bit where hb_req toggles relative to its registered copy and hb_mask=1.
REQ-025 SHALL set a pending flag on any detected edge. Multiple simultaneous or overlapping edges SHALL coalesce into one pending flag.
REQ-026 SHALL emit wd_heartbeat as a registered single-cycle pulse when pending=1 and wd_heartbeat was 0 in the previous cycle. Pending SHALL clear on emission.
- Latency: edge sampled at cycle t -> pulse at t+1, or t+2 if a pulse occurred at t.
- wd_heartbeat SHALL never be high on two consecutive cycles.
REQ-027 SHALL forward heartbeats only in RAMP_UP, RUNNING and WARN. In all other states, pending SHALL be forced to 0 and wd_heartbeat held at 0.

Reset
REQ-028 SHALL, on rst asserted, asynchronously force: state=DISABLED, all outputs 0, amp_scale=0, fault_count=0, pending=0, hb_req copy=0.
REQ-029 SHALL treat rst mid-ramp or in FAULT identically to power-up; fault history is lost.
REQ-030 SHALL synchronise rst deassertion externally. The block SHALL take no action on the first edge after release except sampling hb_req.

Structure
REQ-031 SHALL place the state enum, its 3-bit encoding and the AMP_MAX=255 constant in shared package wd_pkg.
REQ-032 SHALL implement REQ-024..REQ-027 in sub-module hb_merge (ports: clk, rst, hb_req, hb_mask, fwd_en, wd_heartbeat). The FSM and ramp SHALL live in wd_supervisor.

Verification
REQ-033 SHALL cover: rst, arm -> force_reset pulse 1 cycle; amp 0->255 in 16 steps, 64 cycles at defaults; state=RUNNING.
REQ-034 SHALL cover: RUNNING, wd_triggered=1 -> fault_count=1; amp 255->0 in 64 cycles; then FAULT, rf_enable=0, fault_latched=1; clear_fault -> DISABLED.
REQ-035 SHALL cover: hb_req toggles on bits 0 and 2 in the same cycle, mask=4'b1111 -> exactly one wd_heartbeat pulse.
REQ-036 SHALL cover: toggles on consecutive cycles -> pulses separated by at least 1 low cycle. A toggle on a masked-off bit -> no pulse.
REQ-037 SHALL cover: disarm and wd_triggered in the same cycle -> cause=fault, ending in FAULT. disarm alone at amp=128 mid RAMP_UP -> ramp down from 128, then DISABLED.
REQ-038 SHALL cover: rst asserted mid RAMP_DOWN -> all outputs 0 immediately (asynchronously), fault_count=0.

Source files
------------

// File: rtl/wd_pkg.sv
// Shared types and constants for the watchdog supervisor.
package wd_pkg;

  // Supervisor state, 3-bit encoding exported on the state port.
  typedef enum logic [2:0] {
    StDisabled = 3'd0,
    StRampUp   = 3'd1,
    StRunning  = 3'd2,
    StWarn     = 3'd3,
    StRampDown = 3'd4,
    StFault    = 3'd5
  } wd_state_e;

  localparam logic [7:0] AMP_MAX = 8'd255;

  // States in which the watchdog is armed and heartbeats are forwarded.
  function automatic logic wd_active(input wd_state_e s);
    return (s == StRampUp) || (s == StRunning) || (s == StWarn);
  endfunction

endpackage

// File: rtl/hb_merge.sv
// Merges per-requester heartbeat toggles into single, non-back-to-back watchdog pulses.
module hb_merge
  import wd_pkg::*;
#(
  parameter int unsigned N_SRC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] hb_req,
  input  logic [N_SRC-1:0] hb_mask,
  input  logic             fwd_en,
  output logic             wd_heartbeat
);

  logic [N_SRC-1:0] hb_q;
  logic             pending_q;
  logic             toggle_any;
  logic             want;

  assign toggle_any = |((hb_req ^ hb_q) & hb_mask);
  // A new toggle arriving while a pulse is being emitted is carried in pending.
  assign want       = pending_q | toggle_any;

  // Sample requesters, track pending work and emit spaced heartbeat pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_q         <= '0;
      pending_q    <= 1'b0;
      wd_heartbeat <= 1'b0;
    end else begin
      hb_q <= hb_req;
      if (!fwd_en) begin
        pending_q    <= 1'b0;
        wd_heartbeat <= 1'b0;
      end else begin
        wd_heartbeat <= want & ~wd_heartbeat;
        pending_q    <= want & wd_heartbeat;
      end
    end
  end

endmodule

// File: rtl/wd_supervisor.sv
// RF output supervisor: arm/ramp/run/shutdown FSM around an external watchdog timer.
module wd_supervisor
  import wd_pkg::*;
#(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned RAMP_STEP = 16,
  parameter int unsigned RAMP_DIV  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             disarm,
  input  logic             clear_fault,
  input  logic [N_SRC-1:0] hb_req,
  input  logic [N_SRC-1:0] hb_mask,
  input  logic             wd_warning,
  input  logic             wd_triggered,
  output logic             wd_enable,
  output logic             wd_heartbeat,
  output logic             wd_force_reset,
  output logic             rf_enable,
  output logic [7:0]       amp_scale,
  output logic             fault_latched,
  output logic [7:0]       fault_count,
  output logic [2:0]       state
);

  localparam int unsigned    DivW    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(RAMP_DIV - 1);
  // Steps larger than the amplitude range behave as a full-scale jump.
  localparam logic [8:0]     StepW   = 9'((RAMP_STEP > 255) ? 255 : RAMP_STEP);

  wd_state_e       state_q, state_d;
  logic [7:0]      amp_q, amp_d;
  logic [DivW-1:0] div_q, div_d;
  logic            cause_q, cause_d;   // 1 = shutdown caused by watchdog fault
  logic [7:0]      fcnt_q, fcnt_d;
  logic            step;
  logic [8:0]      amp_sum;
  logic [7:0]      amp_up, amp_dn;

  assign step    = (div_q == DivMax);
  assign amp_sum = {1'b0, amp_q} + StepW;
  assign amp_up  = (amp_sum > {1'b0, AMP_MAX}) ? AMP_MAX : amp_sum[7:0];
  assign amp_dn  = ({1'b0, amp_q} > StepW) ? (amp_q - StepW[7:0]) : 8'd0;

  // Next-state, ramp and fault-count logic.
  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    div_d   = div_q;
    cause_d = cause_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      StDisabled: begin
        if (arm) begin
          state_d = StRampUp;
          amp_d   = 8'd0;
          div_d   = '0;
        end
      end
      StRampUp, StRunning, StWarn: begin
        if (wd_triggered) begin
          state_d = StRampDown;
          cause_d = 1'b1;
          div_d   = '0;
          if (fcnt_q != 8'hff) fcnt_d = fcnt_q + 8'd1;
        end else if (disarm) begin
          state_d = StRampDown;
          cause_d = 1'b0;
          div_d   = '0;
        end else if (state_q == StRampUp) begin
          if (step) begin
            div_d = '0;
            amp_d = amp_up;
            if (amp_up == AMP_MAX) state_d = StRunning;
          end else begin
            div_d = div_q + DivW'(1);
          end
        end else if (state_q == StRunning) begin
          if (wd_warning) state_d = StWarn;
        end else begin
          if (!wd_warning) state_d = StRunning;
        end
      end
      StRampDown: begin
        if (step) begin
          div_d = '0;
          amp_d = amp_dn;
          if (amp_dn == 8'd0) state_d = cause_q ? StFault : StDisabled;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StFault: begin
        if (clear_fault) state_d = StDisabled;
      end
      default: state_d = StDisabled;
    endcase
  end

  // State registers; control outputs are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StDisabled;
      amp_q          <= 8'd0;
      div_q          <= '0;
      cause_q        <= 1'b0;
      fcnt_q         <= 8'd0;
      wd_enable      <= 1'b0;
      rf_enable      <= 1'b0;
      wd_force_reset <= 1'b0;
      fault_latched  <= 1'b0;
    end else begin
      state_q        <= state_d;
      amp_q          <= amp_d;
      div_q          <= div_d;
      cause_q        <= cause_d;
      fcnt_q         <= fcnt_d;
      wd_enable      <= wd_active(state_d);
      rf_enable      <= wd_active(state_d) || (state_d == StRampDown);
      wd_force_reset <= (state_q == StDisabled) && (state_d == StRampUp);
      fault_latched  <= (state_d == StFault);
    end
  end

  // Forwarding follows the next state so no pulse leaks into a non-forwarding state.
  hb_merge #(
    .N_SRC(N_SRC)
  ) u_hb_merge (
    .clk         (clk),
    .rst         (rst),
    .hb_req      (hb_req),
    .hb_mask     (hb_mask),
    .fwd_en      (wd_active(state_d)),
    .wd_heartbeat(wd_heartbeat)
  );

  assign amp_scale   = amp_q;
  assign fault_count = fcnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_wd_supervisor.sv
// Self-checking bench for wd_supervisor with a heartbeat pulse scoreboard.
module tb_wd_supervisor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0, disarm = 1'b0, clear_fault = 1'b0;
  logic [3:0] hb_req = 4'b0000, hb_mask = 4'b1111;
  logic       wd_warning = 1'b0, wd_triggered = 1'b0;
  logic       wd_enable, wd_heartbeat, wd_force_reset, rf_enable, fault_latched;
  logic [7:0] amp_scale, fault_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];   // cycle numbers at which a heartbeat pulse is expected
  logic hb_prev = 1'b0;
  int c0, c1;

  wd_supervisor dut (
    .clk           (clk),
    .rst           (rst),
    .arm           (arm),
    .disarm        (disarm),
    .clear_fault   (clear_fault),
    .hb_req        (hb_req),
    .hb_mask       (hb_mask),
    .wd_warning    (wd_warning),
    .wd_triggered  (wd_triggered),
    .wd_enable     (wd_enable),
    .wd_heartbeat  (wd_heartbeat),
    .wd_force_reset(wd_force_reset),
    .rf_enable     (rf_enable),
    .amp_scale     (amp_scale),
    .fault_latched (fault_latched),
    .fault_count   (fault_count),
    .state         (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until the state differs from cur, or the budget runs out.
  task automatic run_while(input logic [2:0] cur, input int budget);
    int n;
    n = 0;
    while (state == cur && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("timeout", n, -1);
  endtask

  function automatic int all_outs();
    return int'({wd_enable, wd_heartbeat, wd_force_reset, rf_enable, fault_latched,
                 state, amp_scale, fault_count});
  endfunction

  // Heartbeat scoreboard: every observed pulse pops one expected cycle.
  always @(negedge clk) begin
    if (!rst && wd_heartbeat) begin
      check("hb_gap", int'(hb_prev), 0);
      if (exp_q.size() == 0) check("hb_unexpected", cyc, -1);
      else check("hb_cycle", cyc, exp_q.pop_front());
    end
    hb_prev = wd_heartbeat;
  end

  initial begin
    #3;
    check("rst_outputs", all_outs(), 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("idle_state", int'(state), 0);

    // Arm and ramp up.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    c0 = cyc;
    check("rampup_state", int'(state), 1);
    check("force_reset_on", int'(wd_force_reset), 1);
    check("rampup_enables", int'({wd_enable, rf_enable}), 3);
    tick();
    check("force_reset_off", int'(wd_force_reset), 0);
    while (state == 3'd1 && cyc - c0 < 200) begin
      tick();
      if (cyc - c0 == 32) check("rampup_amp_mid", int'(amp_scale), 128);
    end
    check("rampup_len", cyc - c0, 64);
    check("running_state", int'(state), 2);
    check("running_amp", int'(amp_scale), 255);

    // Coalesced simultaneous toggles on bits 0 and 2.
    hb_req = hb_req ^ 4'b0101;
    exp_q.push_back(cyc + 1);
    repeat (5) tick();
    // Back-to-back toggles: second pulse is held off by one cycle.
    hb_req = hb_req ^ 4'b0010;
    exp_q.push_back(cyc + 1);
    tick();
    hb_req = hb_req ^ 4'b1000;
    exp_q.push_back(cyc + 2);
    repeat (5) tick();
    // Masked-off requester must not produce a pulse.
    hb_mask = 4'b1110;
    hb_req  = hb_req ^ 4'b0001;
    repeat (5) tick();
    hb_mask = 4'b1111;
    repeat (2) tick();
    check("hb_outstanding", exp_q.size(), 0);

    // Warning round trip.
    wd_warning = 1'b1;
    tick();
    check("warn_state", int'(state), 3);
    check("warn_wd_enable", int'(wd_enable), 1);
    wd_warning = 1'b0;
    tick();
    check("warn_exit", int'(state), 2);

    // Watchdog trigger -> ramp down -> FAULT.
    wd_triggered = 1'b1;
    tick();
    wd_triggered = 1'b0;
    c0 = cyc;
    check("trig_state", int'(state), 4);
    check("trig_fault_count", int'(fault_count), 1);
    check("trig_amp", int'(amp_scale), 255);
    check("trig_enables", int'({wd_enable, rf_enable}), 1);
    run_while(3'd4, 200);
    check("rampdown_len", cyc - c0, 64);
    check("fault_state", int'(state), 5);
    check("fault_outs", int'({rf_enable, fault_latched, amp_scale}), 9'h100);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_in_fault", int'(state), 5);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("clear_state", int'({state, fault_latched}), 0);

    // Clean disarm at amp=128 mid ramp-up.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    c0 = cyc;
    while (amp_scale != 8'd128 && cyc - c0 < 200) tick();
    check("disarm_at", cyc - c0, 32);
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    c1 = cyc;
    check("disarm_state", int'(state), 4);
    check("disarm_amp", int'(amp_scale), 128);
    check("disarm_fcnt", int'(fault_count), 1);
    run_while(3'd4, 200);
    check("disarm_down_len", cyc - c1, 32);
    check("disarm_end", int'(state), 0);
    check("disarm_fcnt_end", int'(fault_count), 1);

    // Disarm and trigger together: trigger wins.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (9) tick();
    disarm       = 1'b1;
    wd_triggered = 1'b1;
    tick();
    disarm       = 1'b0;
    wd_triggered = 1'b0;
    check("both_state", int'(state), 4);
    check("both_fcnt", int'(fault_count), 2);
    run_while(3'd4, 200);
    check("both_end", int'(state), 5);

    // Asynchronous reset in the middle of a ramp-down.
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    run_while(3'd1, 200);
    wd_triggered = 1'b1;
    tick();
    wd_triggered = 1'b0;
    repeat (10) tick();
    check("pre_rst_state", int'(state), 4);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outs", all_outs(), 0);
    check("async_rst_fcnt", int'(fault_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
